grid_vga_renderer: RTL and testbench
====================================

// Module: grid_vga_renderer
// PURPOSE
//  Reader side of the playfield grid bus: consumes the 22x10x3 colour grid that the game FSM drives and scans it to a 640x480@60 VGA display.
//  Grid is snapshotted once per frame at start of vertical blanking (tear-free); pixels are produced by a 2-stage pipeline with matched syncs.
//  Sits between the game FSM grid output and the board's VGA pins.
// PARAMETERS
//  H_ACTIVE 640 visible px/line;  H_FP 16;  H_SYNC 96;  H_BP 48  (line = 800)
//  V_ACTIVE 480 visible lines;    V_FP 10;  V_SYNC 2;   V_BP 33  (frame = 525)
//  CELL_PX  20  cell edge in pixels (board = 200 x 440 px)
//  BOARD_X0 220 first board pixel column;  BOARD_Y0 20 first board line
// PORTS
//  clk      in   1      system clock
//  rst_n    in   1      reset, asynchronous, active-low
//  pix_en   in   1      pixel-rate strobe (1 in 4 clk at 100 MHz); all scan state advances only when high
//  grid_i   in   660    [21:0][9:0][2:0] colour grid, row 0 = top, col 0 = left
//  hsync_o  out  1      horizontal sync, active-low
//  vsync_o  out  1      vertical sync, active-low
//  de_o     out  1      display enable (active video, pipeline-aligned)
//  red_o    out  4      red;  green_o out 4 green;  blue_o out 4 blue
//  frame_o  out  1      1-clk pulse when grid snapshot is taken
// BEHAVIOUR
//  Clocking: one clock; reset is asynchronous and active-low.
//  Reset values: hcnt=0, vcnt=0, snapshot=0, hsync_o=1, vsync_o=1, de_o=0, rgb=0, frame_o=0, pipeline regs cleared.
//  Counters (advance on pix_en only): hcnt 0..799 wraps to 0; vcnt increments on hcnt wrap, 0..524 wraps to 0.
//  Raw timing: active = hcnt<640 && vcnt<480; hsync low for hcnt 656..751; vsync low for vcnt 490..491.
//  Snapshot: on the pix_en cycle where hcnt=0 and vcnt=480, snapshot<=grid_i and frame_o=1 for that clk; grid_i ignored otherwise.
//  Stage 1 (pix_en): compute inside = BOARD_X0<=hcnt<BOARD_X0+200 && BOARD_Y0<=vcnt<BOARD_Y0+440;
//   col=(hcnt-BOARD_X0)/CELL_PX (0..9), row=(vcnt-BOARD_Y0)/CELL_PX (0..21); no divider: use running sub-cell counters reset at board edge.
//   border = pixel exactly one outside the board rectangle (x=219 or 420 with y in 19..460, y=19 or 460 with x in 219..420).
//  Stage 2 (pix_en): idx=snapshot[row][col] if inside; register rgb via palette; border -> 0xFFF; else 0x000; !active -> rgb forced 0x000.
//  Palette (RGB444): 0 000, 1 0FF, 2 FF0, 3 A0F, 4 0F0, 5 F00, 6 00F, 7 F80.
//  Latency: hsync_o, vsync_o, de_o and rgb all delayed exactly 2 pix_en ticks from raw counter values; all four stay mutually aligned.
//  pix_en low: every register holds (outputs static); no counter skips or double-steps.
//  Grid change mid-frame: no effect until next snapshot. Reset mid-frame: outputs go to reset values immediately; scan restarts at (0,0).
//  Row 21 (floor, all colour 7) is displayed as the bottom orange row; no row is hidden.
// TESTING
//  Reset, pix_en=1 continuously, grid all 0 -> hsync period 800 ticks, low 96; vsync period 420000 ticks, low 1600; rgb always 000.
//  grid[0][0]=3, rest 0 -> pixels x220..239, y20..39 = A0F, de_o=1; pixel (240,20)=000; (219,20)=FFF.
//  grid[21][*]=7 -> lines 440..459, x220..419 = F80; line 460 x219..420 = FFF.
//  Change grid_i[5][5] 0->5 at vcnt=100 -> not visible this frame; frame_o pulses at (0,480); next frame cell (5,5) = F00.
//  pix_en 1-in-4 -> identical output sequence to continuous case, each value held 4 clk.
//  Assert rst_n low at vcnt=200 for 3 clk -> outputs at reset values during reset; first pix_en after release gives hcnt=0,vcnt=0.

Source files
------------

// File: rtl/grid_vga_renderer.sv
// grid_vga_renderer
// Reader side of the playfield grid bus. Takes the 22x10 cell colour grid
// driven by the game FSM, freezes a copy once per frame at the start of
// vertical blanking (so a frame is never torn), and scans it out as 640x480@60
// VGA through a two-stage pixel pipeline whose syncs are delayed to match.
//
// Ports
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   pix_en   pixel-rate strobe; all scan state advances only when high
//   grid_i   [21:0][9:0][2:0] colour indices, row 0 = top, col 0 = left
//   hsync_o  horizontal sync, active-low
//   vsync_o  vertical sync, active-low
//   de_o     display enable, aligned with the colour outputs
//   red_o / green_o / blue_o   RGB444 pixel colour
//   frame_o  one-clk pulse when the grid snapshot is taken
module grid_vga_renderer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CELL_PX  = 20,
  parameter int BOARD_X0 = 220,
  parameter int BOARD_Y0 = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_en,
  input  logic [21:0][9:0][2:0] grid_i,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  de_o,
  output logic [3:0]            red_o,
  output logic [3:0]            green_o,
  output logic [3:0]            blue_o,
  output logic                  frame_o
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  // Board rectangle: [BX0,BX1) x [BY0,BY1); the border ring sits one pixel outside it
  localparam logic [9:0] BX0      = 10'(BOARD_X0);
  localparam logic [9:0] BX1      = 10'(BOARD_X0 + 10 * CELL_PX);
  localparam logic [9:0] BY0      = 10'(BOARD_Y0);
  localparam logic [9:0] BY1      = 10'(BOARD_Y0 + 22 * CELL_PX);
  localparam logic [9:0] BXL      = 10'(BOARD_X0 - 1);
  localparam logic [9:0] BYL      = 10'(BOARD_Y0 - 1);
  localparam logic [4:0] SUB_LAST = 5'(CELL_PX - 1);

  logic [9:0]                hcnt, vcnt;
  logic [4:0]                sub_x, sub_y;
  logic [3:0]                col;
  logic [4:0]                row;
  logic [21:0][9:0][2:0]     snapshot;

  logic                      s1_active, s1_hsync, s1_vsync, s1_inside, s1_border;
  logic [3:0]                s1_col;
  logic [4:0]                s1_row;
  logic [11:0]               rgb;

  logic                      raw_active, raw_hsync, raw_vsync, raw_inside, raw_border;
  logic                      line_end;
  logic [2:0]                cell_idx;

  function automatic logic [11:0] palette(input logic [2:0] idx);
    case (idx)
      3'd1:    return 12'h0FF;
      3'd2:    return 12'hFF0;
      3'd3:    return 12'hA0F;
      3'd4:    return 12'h0F0;
      3'd5:    return 12'hF00;
      3'd6:    return 12'h00F;
      3'd7:    return 12'hF80;
      default: return 12'h000;
    endcase
  endfunction

  assign line_end = (hcnt == H_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en) begin
      if (line_end) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  // Cell coordinates track hcnt/vcnt without a divider: each sub-cell counter
  // is forced to zero as the scan enters the board edge, then counts pixels
  // within a cell. col/row run on past the board but are only used inside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_x <= '0;
      col   <= '0;
      sub_y <= '0;
      row   <= '0;
    end else if (pix_en) begin
      if (hcnt == BXL) begin
        sub_x <= '0;
        col   <= '0;
      end else if (sub_x == SUB_LAST) begin
        sub_x <= '0;
        col   <= col + 4'd1;
      end else begin
        sub_x <= sub_x + 5'd1;
      end
      if (line_end) begin
        if (vcnt == BYL) begin
          sub_y <= '0;
          row   <= '0;
        end else if (sub_y == SUB_LAST) begin
          sub_y <= '0;
          row   <= row + 5'd1;
        end else begin
          sub_y <= sub_y + 5'd1;
        end
      end
    end
  end

  // Grid is captured only at the first blanking line so a whole frame
  // is drawn from a single consistent copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snapshot <= '0;
      frame_o  <= 1'b0;
    end else begin
      frame_o <= 1'b0;
      if (pix_en && hcnt == 10'd0 && vcnt == V_VIS) begin
        snapshot <= grid_i;
        frame_o  <= 1'b1;
      end
    end
  end

  assign raw_active = (hcnt < H_VIS) && (vcnt < V_VIS);
  assign raw_hsync  = !((hcnt >= HS_FIRST) && (hcnt <= HS_LAST));
  assign raw_vsync  = !((vcnt >= VS_FIRST) && (vcnt <= VS_LAST));
  assign raw_inside = (hcnt >= BX0) && (hcnt < BX1) && (vcnt >= BY0) && (vcnt < BY1);
  assign raw_border = (((hcnt == BXL) || (hcnt == BX1)) && (vcnt >= BYL) && (vcnt <= BY1)) ||
                      (((vcnt == BYL) || (vcnt == BY1)) && (hcnt >= BXL) && (hcnt <= BX1));

  // Sync pipeline registers reset to the inactive (high) level so no
  // spurious sync pulse leaves the pipeline after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_active <= 1'b0;
      s1_hsync  <= 1'b1;
      s1_vsync  <= 1'b1;
      s1_inside <= 1'b0;
      s1_border <= 1'b0;
      s1_col    <= '0;
      s1_row    <= '0;
    end else if (pix_en) begin
      s1_active <= raw_active;
      s1_hsync  <= raw_hsync;
      s1_vsync  <= raw_vsync;
      s1_inside <= raw_inside;
      s1_border <= raw_border;
      s1_col    <= col;
      s1_row    <= row;
    end
  end

  assign cell_idx = s1_inside ? snapshot[s1_row][s1_col] : 3'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
      de_o    <= 1'b0;
      rgb     <= '0;
    end else if (pix_en) begin
      hsync_o <= s1_hsync;
      vsync_o <= s1_vsync;
      de_o    <= s1_active;
      if (!s1_active) begin
        rgb <= 12'h000;
      end else if (s1_inside) begin
        rgb <= palette(cell_idx);
      end else if (s1_border) begin
        rgb <= 12'hFFF;
      end else begin
        rgb <= 12'h000;
      end
    end
  end

  assign red_o   = rgb[11:8];
  assign green_o = rgb[7:4];
  assign blue_o  = rgb[3:0];

endmodule

// File: tb/tb_grid_vga_renderer.sv
// tb_grid_vga_renderer
// Two renderer instances share one clock and reset: "dut_full" keeps the real
// 640x480 timing and is used for line-level sync/enable timing and the border
// at its true coordinates; "dut" shrinks the screen (40x57 ticks, 2-pixel
// cells, board at (6,3)) so whole frames, snapshots and the mid-frame reset
// fit in a short run. Expected values are hand-computed constants.
module tb_grid_vga_renderer;

  localparam int HT = 40;
  localparam int VT = 57;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  pix_en = 1'b0;
  logic                  pix_en_full = 1'b0;
  logic [21:0][9:0][2:0] grid = '0;
  logic [21:0][9:0][2:0] grid_full = '0;

  logic       hsync_o, vsync_o, de_o, frame_o;
  logic [3:0] red_o, green_o, blue_o;
  logic       hsync_f, vsync_f, de_f, frame_f;
  logic [3:0] red_f, green_f, blue_f;
  logic [11:0] rgb, rgb_f;

  assign rgb   = {red_o, green_o, blue_o};
  assign rgb_f = {red_f, green_f, blue_f};

  grid_vga_renderer #(
    .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(50), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CELL_PX(2), .BOARD_X0(6), .BOARD_Y0(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .grid_i(grid),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o), .frame_o(frame_o)
  );

  grid_vga_renderer dut_full (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en_full), .grid_i(grid_full),
    .hsync_o(hsync_f), .vsync_o(vsync_f), .de_o(de_f),
    .red_o(red_f), .green_o(green_f), .blue_o(blue_f), .frame_o(frame_f)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Position model for the small instance: raw counter, stage-1 and output positions
  int rx = 0, ry = 0, sx = 0, sy = 0, ox = 0, oy = 0;
  bit sv = 0, ov = 0;
  bit div4 = 0;
  int frame_cnt = 0, frame_x = -1, frame_y = -1;
  int hold_errs = 0;
  int last_ticks = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One pixel tick of the small instance; in 1-in-4 mode the outputs must
  // stay frozen for the three strobe-less clocks that follow.
  task automatic tick();
    logic [14:0] held;
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    ox = sx; oy = sy; ov = sv;
    sx = rx; sy = ry; sv = 1'b1;
    rx++;
    if (rx == HT) begin
      rx = 0;
      ry++;
      if (ry == VT) ry = 0;
    end
    if (frame_o) begin
      frame_cnt++;
      frame_x = sx;
      frame_y = sy;
    end
    if (div4) begin
      held = {hsync_o, vsync_o, de_o, rgb};
      pix_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk);
        #1;
        if ({hsync_o, vsync_o, de_o, rgb} !== held || frame_o !== 1'b0) hold_errs++;
      end
    end
  endtask

  // Advance until the outputs show pixel (x,y)
  task automatic applyStimulus(input int x, input int y);
    int n;
    n = 0;
    while (!(ov && ox == x && oy == y) && n < HT * VT + 4) begin
      tick();
      n++;
    end
    last_ticks = n;
    if (!(ov && ox == x && oy == y)) checkOutput("timeout", 32'd1, 32'd0);
  endtask

  task automatic checkPix(input string tag, input int x, input int y,
                          input logic [11:0] exp_rgb);
    applyStimulus(x, y);
    checkOutput(tag, {20'd0, rgb}, {20'd0, exp_rgb});
  endtask

  task automatic resetModel();
    rx = 0; ry = 0; sx = 0; sy = 0; ox = 0; oy = 0; sv = 0; ov = 0;
  endtask

  initial begin
    int hf1, hf2, hr1, der, def, nz, vlow, n;
    logic hs_prev, de_prev;

    // ---- reset state, real-timing instance ----
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_full_hsync", 32'(hsync_f), 32'd1);
    checkOutput("rst_full_vsync", 32'(vsync_f), 32'd1);
    checkOutput("rst_full_de", 32'(de_f), 32'd0);
    checkOutput("rst_full_rgb", 32'(rgb_f), 32'd0);
    checkOutput("rst_full_frame", 32'(frame_f), 32'd0);
    rst_n = 1'b1;
    pix_en_full = 1'b1;

    hf1 = -1; hf2 = -1; hr1 = -1; der = -1; def = -1; nz = 0; vlow = 0;
    hs_prev = 1'b1; de_prev = 1'b0;
    for (int c = 1; c <= 16225; c++) begin
      @(posedge clk);
      #1;
      n = c - 2;
      if (hs_prev && !hsync_f && hf1 < 0) hf1 = c;
      else if (hs_prev && !hsync_f && hf2 < 0) hf2 = c;
      if (!hs_prev && hsync_f && hr1 < 0) hr1 = c;
      if (!de_prev && de_f && der < 0) der = c;
      if (de_prev && !de_f && def < 0) def = c;
      if (!vsync_f) vlow++;
      if (n >= 0 && n < 19 * 800 && rgb_f != 12'h000) nz++;
      if (n == 19 * 800 + 218) checkOutput("full_pre_border", 32'(rgb_f), 32'h000);
      if (n == 19 * 800 + 219) checkOutput("full_border_corner", 32'(rgb_f), 32'hFFF);
      if (n == 20 * 800 + 220) begin
        checkOutput("full_cell_rgb", 32'(rgb_f), 32'h000);
        checkOutput("full_cell_de", 32'(de_f), 32'd1);
      end
      hs_prev = hsync_f;
      de_prev = de_f;
    end
    checkOutput("full_hsync_first_fall", 32'(hf1), 32'd658);
    checkOutput("full_hsync_low", 32'(hr1 - hf1), 32'd96);
    checkOutput("full_hsync_period", 32'(hf2 - hf1), 32'd800);
    checkOutput("full_de_rise", 32'(der), 32'd2);
    checkOutput("full_de_width", 32'(def - der), 32'd640);
    checkOutput("full_vsync_low_count", 32'(vlow), 32'd0);
    checkOutput("full_blank_rows_rgb", 32'(nz), 32'd0);
    pix_en_full = 1'b0;

    // ---- small instance: grid with cell (0,0)=3 and floor row all 7 ----
    grid[0][0] = 3'd3;
    for (int c = 0; c < 10; c++) grid[21][c] = 3'd7;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_hsync", 32'(hsync_o), 32'd1);
    checkOutput("rst_vsync", 32'(vsync_o), 32'd1);
    checkOutput("rst_de", 32'(de_o), 32'd0);
    checkOutput("rst_rgb", 32'(rgb), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    resetModel();

    // Frame 0 draws the cleared snapshot
    checkPix("f0_border_left", 5, 3, 12'hFFF);
    checkPix("f0_cell00_empty", 6, 3, 12'h000);
    applyStimulus(0, 50);
    checkOutput("f0_frame_count", 32'(frame_cnt), 32'd1);
    checkOutput("f0_frame_x", 32'(frame_x), 32'd0);
    checkOutput("f0_frame_y", 32'(frame_y), 32'd50);
    checkOutput("f0_blank_de", 32'(de_o), 32'd0);
    applyStimulus(0, 51);
    checkOutput("vsync_before", 32'(vsync_o), 32'd1);
    applyStimulus(0, 52);
    checkOutput("vsync_first", 32'(vsync_o), 32'd0);
    applyStimulus(39, 53);
    checkOutput("vsync_last", 32'(vsync_o), 32'd0);
    applyStimulus(0, 54);
    checkOutput("vsync_after", 32'(vsync_o), 32'd1);

    // Frame 1 shows the snapshot
    checkPix("f1_border_left", 5, 3, 12'hFFF);
    checkPix("f1_cell00_first", 6, 3, 12'hA0F);
    checkOutput("f1_cell00_de", 32'(de_o), 32'd1);
    checkPix("f1_cell00_x7", 7, 3, 12'hA0F);
    checkPix("f1_cell01", 8, 3, 12'h000);
    checkPix("f1_cell00_last", 7, 4, 12'hA0F);
    checkPix("f1_cell10", 6, 5, 12'h000);
    applyStimulus(31, 5);
    checkOutput("de_last_active", 32'(de_o), 32'd1);
    applyStimulus(32, 5);
    checkOutput("de_first_blank", 32'(de_o), 32'd0);
    applyStimulus(33, 5);
    checkOutput("hsync_before", 32'(hsync_o), 32'd1);
    applyStimulus(34, 5);
    checkOutput("hsync_first", 32'(hsync_o), 32'd0);
    applyStimulus(37, 5);
    checkOutput("hsync_last", 32'(hsync_o), 32'd0);
    applyStimulus(38, 5);
    checkOutput("hsync_after", 32'(hsync_o), 32'd1);

    // Grid change mid-frame must wait for the next snapshot
    applyStimulus(0, 10);
    grid[5][5] = 3'd5;
    checkPix("f1_cell55_unchanged", 16, 13, 12'h000);
    checkPix("f1_row20", 6, 43, 12'h000);
    checkPix("f1_floor_first", 6, 45, 12'hF80);
    checkPix("f1_floor_last", 25, 46, 12'hF80);
    checkPix("f1_border_right", 26, 46, 12'hFFF);
    checkPix("f1_border_bl", 5, 47, 12'hFFF);
    checkPix("f1_border_br", 26, 47, 12'hFFF);
    checkPix("f1_past_border", 27, 47, 12'h000);
    checkPix("f1_below_border", 6, 48, 12'h000);
    applyStimulus(0, 50);
    checkOutput("f1_frame_count", 32'(frame_cnt), 32'd2);

    // Frame 2 at 1-in-4 strobe rate
    div4 = 1'b1;
    hold_errs = 0;
    checkPix("f2_cell54", 15, 13, 12'h000);
    checkPix("f2_cell55_first", 16, 13, 12'hF00);
    checkPix("f2_cell55_last", 17, 14, 12'hF00);
    checkOutput("div4_hold", 32'(hold_errs), 32'd0);
    div4 = 1'b0;

    // Reset mid-frame
    applyStimulus(0, 20);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_hsync", 32'(hsync_o), 32'd1);
    checkOutput("midrst_de", 32'(de_o), 32'd0);
    checkOutput("midrst_rgb", 32'(rgb), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midrst_vsync", 32'(vsync_o), 32'd1);
    rst_n = 1'b1;
    resetModel();
    applyStimulus(0, 0);
    checkOutput("midrst_latency", 32'(last_ticks), 32'd2);
    checkOutput("midrst_origin_de", 32'(de_o), 32'd1);
    checkPix("midrst_border", 5, 3, 12'hFFF);
    checkPix("midrst_snapshot_cleared", 16, 13, 12'h000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
